// File: rtl/execute_muldiv_controller.sv
// execute_muldiv_controller
// Iterative RV64 M-extension sequencer for the execute stage. It runs a
// shift-add multiply or a restoring divide at one bit per cycle, so a normal
// op returns its result 65 cycles after start. Divide-by-zero and signed
// overflow are resolved at capture and return one cycle after start.
//
// Ports
//   clock                   rising-edge clock
//   reset                   asynchronous, active-high reset
//   start                   execute stage presents a valid M-op
//   flush                   kill the in-flight op (redirect)
//   op[2:0]                 000 MUL, 001 MULHU, 010 DIVU, 011 REMU,
//                           100 DIV, 101 REM, 11x treated as MUL
//   operand_a[XLEN-1:0]     rs1 (multiplicand / dividend)
//   operand_b[XLEN-1:0]     rs2 (multiplier / divisor)
//   destination_register_d  rd of the op being presented
//   stall                   freeze IF/ID/EX
//   busy                    high in BUSY or DONE
//   result_valid            result present this cycle
//   result[XLEN-1:0]        operation result, held until the next capture
//   destination_register_e  rd captured with the op
module execute_muldiv_controller #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      destination_register_d,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      destination_register_e
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CW-1:0]       count_reg;
  // Multiply: {upper partial product, multiplier}.
  // Divide:   {remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0]   acc_reg;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]     opnd_reg;
  logic                is_div_reg;
  logic                sel_hi_reg;   // result taken from the upper half
  logic                neg_q_reg;    // quotient must be negated
  logic                neg_r_reg;    // remainder must be negated
  logic [XLEN-1:0]     result_reg;
  logic [4:0]          rd_reg;

  // Decode of the presented op
  logic                op_is_div;
  logic                op_signed;
  logic                op_rem;
  logic                op_sel_hi;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                div_by_zero;
  logic                div_overflow;
  logic                special_case;
  logic [XLEN-1:0]     special_result;

  // One iteration of the datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_shift;
  logic [XLEN-1:0]     rem_diff;
  logic                rem_ge;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   acc_next;
  logic [XLEN-1:0]     raw_result;
  logic                negate_result;
  logic [XLEN-1:0]     final_result;

  always_comb begin
    op_is_div    = (op == 3'b010) || (op == 3'b011) ||
                   (op == 3'b100) || (op == 3'b101);
    op_signed    = (op == 3'b100) || (op == 3'b101);
    op_rem       = (op == 3'b011) || (op == 3'b101);
    op_sel_hi    = (op == 3'b001) || op_rem;

    a_neg        = op_signed && operand_a[XLEN-1];
    b_neg        = op_signed && operand_b[XLEN-1];
    a_mag        = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag        = b_neg ? (~operand_b + 1'b1) : operand_b;

    div_by_zero  = op_is_div && (operand_b == '0);
    div_overflow = op_signed && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (operand_b == '1);
    special_case = div_by_zero || div_overflow;

    if (div_by_zero) begin
      special_result = op_rem ? operand_a : '1;
    end else begin
      special_result = op_rem ? '0 : operand_a;
    end
  end

  always_comb begin
    // Shift-add step; the 65-bit sum keeps the carry as the new top bit.
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
    if (acc_reg[0]) begin
      mul_next = {mul_sum, acc_reg[XLEN-1:1]};
    end else begin
      mul_next = {1'b0, acc_reg[2*XLEN-1:1]};
    end

    // Restoring step. The shifted remainder needs XLEN+1 bits because the
    // remainder may have its top bit set when the divisor is above 2^(XLEN-1).
    // When it is >= divisor the true difference fits in XLEN bits.
    rem_shift = acc_reg[2*XLEN-1:XLEN-1];
    rem_ge    = rem_shift >= {1'b0, opnd_reg};
    rem_diff  = rem_shift[XLEN-1:0] - opnd_reg;
    if (rem_ge) begin
      div_next = {rem_diff, acc_reg[XLEN-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end

    acc_next      = is_div_reg ? div_next : mul_next;
    raw_result    = sel_hi_reg ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    negate_result = sel_hi_reg ? neg_r_reg : neg_q_reg;
    final_result  = negate_result ? (~raw_result + 1'b1) : raw_result;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      sel_hi_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      rd_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            is_div_reg <= op_is_div;
            sel_hi_reg <= op_sel_hi;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            rd_reg     <= destination_register_d;
            count_reg  <= '0;
            acc_reg    <= op_is_div ? {{XLEN{1'b0}}, a_mag}
                                    : {{XLEN{1'b0}}, operand_b};
            opnd_reg   <= op_is_div ? b_mag : operand_a;
            if (special_case) begin
              result_reg <= special_result;
              state_reg  <= DONE;
            end else begin
              state_reg  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_ITER) begin
              result_reg <= final_result;
              state_reg  <= DONE;
            end
          end
        end
        DONE: begin
          // start is still high from the stalled pipeline; never re-capture.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The start cycle itself must be held, hence the combinational term.
  // Reset gates stall so a held start cannot freeze the pipe during reset.
  assign stall = !reset &&
                 (((state_reg == IDLE) && start && !flush) || (state_reg == BUSY));
  assign busy                   = (state_reg != IDLE);
  assign result_valid           = (state_reg == DONE) && !flush;
  assign result                 = result_reg;
  assign destination_register_e = rd_reg;

endmodule

// File: tb/tb_execute_muldiv_controller.sv
module tb_execute_muldiv_controller;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic [4:0]  rd_d;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;
  logic [4:0]  rd_e;

  execute_muldiv_controller #(.XLEN(XLEN)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .flush                  (flush),
    .op                     (op),
    .operand_a              (operand_a),
    .operand_b              (operand_b),
    .destination_register_d (rd_d),
    .stall                  (stall),
    .busy                   (busy),
    .result_valid           (result_valid),
    .result                 (result),
    .destination_register_e (rd_e)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (architectural rules) ----------------
  function automatic bit is_special(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    bit divop;
    divop = (o == 3'd2) || (o == 3'd3) || (o == 3'd4) || (o == 3'd5);
    return (divop && b == 64'd0) ||
           ((o == 3'd4 || o == 3'd5) && a == MIN_NEG && b == ALL1);
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sr;
    p  = {64'd0, a} * {64'd0, b};
    sa = a;
    sb = b;
    case (o)
      3'd1: return p[127:64];
      3'd2: return (b == 64'd0) ? ALL1 : a / b;
      3'd3: return (b == 64'd0) ? a : a % b;
      3'd4: begin
        if (b == 64'd0) return ALL1;
        if (a == MIN_NEG && b == ALL1) return a;
        sr = sa / sb;
        return sr;
      end
      3'd5: begin
        if (b == 64'd0) return a;
        if (a == MIN_NEG && b == ALL1) return 64'd0;
        sr = sa % sb;
        return sr;
      end
      default: return p[63:0];
    endcase
  endfunction

  // m_cnt: -1 idle, >0 cycles left until the result cycle, 0 result cycle.
  int          m_cnt = -1;
  logic [63:0] m_pend = '0;
  logic [63:0] m_last_res = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt      <= -1;
      m_last_res <= '0;
      m_rd       <= '0;
    end else if (m_cnt < 0) begin
      if (start && !flush) begin
        m_pend <= ref_result(op, operand_a, operand_b);
        m_rd   <= rd_d;
        if (is_special(op, operand_a, operand_b)) begin
          m_cnt      <= 0;
          m_last_res <= ref_result(op, operand_a, operand_b);
        end else begin
          m_cnt <= 64;
        end
      end
    end else if (flush || m_cnt == 0) begin
      m_cnt <= -1;
    end else begin
      if (m_cnt == 1) m_last_res <= m_pend;
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic exp_stall, exp_busy, exp_valid;
  always @(negedge clock) begin
    if (check_en && !reset) begin
      exp_busy  = (m_cnt >= 0);
      exp_valid = (m_cnt == 0) && !flush;
      exp_stall = ((m_cnt < 0) && start && !flush) || (m_cnt > 0);
      check("cyc stall", 64'(stall), 64'(exp_stall));
      check("cyc busy", 64'(busy), 64'(exp_busy));
      check("cyc result_valid", 64'(result_valid), 64'(exp_valid));
      check("cyc result", result, m_last_res);
      check("cyc rd_e", 64'(rd_e), 64'(m_rd));
    end
  end

  // ---------------- stimulus tasks ----------------
  // Presents an op in the next cycle, holds start high like a stalled
  // pipeline, and returns at the low phase of the result cycle.
  task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp_res, input int exp_lat,
                       input string name);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; flush = 1'b0; op = o; operand_a = a; operand_b = b; rd_d = rd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check({name, " valid seen"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result, exp_res);
    check({name, " rd"}, 64'(rd_e), 64'(rd));
    $display("[TB] op=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", o, a, b, rd, result, lat);
  endtask

  // Presents an op and raises flush in cycle 'at' after start (0 = same
  // cycle as start), with start held until the op is gone.
  task automatic flush_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int at);
    @(posedge clock); #1;
    start = 1'b1; flush = (at == 0); op = o; operand_a = a; operand_b = b; rd_d = rd;
    if (at > 0) begin
      repeat (at) @(posedge clock);
      #1;
      flush = 1'b1;
    end
    @(negedge clock);
    check("flush cycle result_valid", 64'(result_valid), 64'd0);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("after flush busy", 64'(busy), 64'd0);
    check("after flush stall", 64'(stall), 64'd0);
    check("after flush result_valid", 64'(result_valid), 64'd0);
    $display("[TB] flush op=%0d a=%h b=%h at cycle %0d", o, a, b, at);
  endtask

  task automatic go_idle(input int n);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clock);
  endtask

  initial begin
    logic [2:0]  o;
    logic [63:0] a;
    logic [63:0] b;
    int          sel;
    bit          sp;

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    operand_a = '0; operand_b = '0; rd_d = '0;
    #2 reset = 1'b1;
    #20 reset = 1'b0;
    check_en = 1'b1;

    @(negedge clock);
    check("reset stall", 64'(stall), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset rd_e", 64'(rd_e), 64'd0);

    // Directed ops, issued back to back
    do_op(3'd0, 64'd3, 64'd4, 5'd9, 64'hC, 65, "MUL 3x4");
    do_op(3'd1, ALL1, 64'd2, 5'd1, 64'h1, 65, "MULHU");
    do_op(3'd2, 64'd100, 64'd7, 5'd2, 64'd14, 65, "DIVU 100/7");
    do_op(3'd3, 64'd100, 64'd7, 5'd3, 64'd2, 65, "REMU 100/7");
    do_op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65, "DIV -7/2");
    do_op(3'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, ALL1, 65, "REM -7/2");
    do_op(3'd2, 64'd5, 64'd0, 5'd6, ALL1, 1, "DIVU 5/0");
    do_op(3'd3, 64'd5, 64'd0, 5'd7, 64'd5, 1, "REMU 5/0");
    do_op(3'd4, MIN_NEG, ALL1, 5'd8, MIN_NEG, 1, "DIV overflow");
    do_op(3'd5, MIN_NEG, ALL1, 5'd10, 64'd0, 1, "REM overflow");
    do_op(3'd6, 64'd5, 64'd5, 5'd11, 64'd25, 65, "reserved as MUL");
    go_idle(3);

    // Flush mid-divide, then a fresh multiply
    flush_op(3'd2, 64'd100, 64'd7, 5'd12, 20);
    go_idle(5);
    do_op(3'd0, 64'd6, 64'd7, 5'd13, 64'd42, 65, "MUL 6x7 after flush");

    // Asynchronous reset in the middle of a multiply, start still held
    @(posedge clock); #1;
    start = 1'b1; op = 3'd0; operand_a = 64'd123; operand_b = 64'd456; rd_d = 5'd14;
    repeat (30) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async reset stall", 64'(stall), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset result_valid", 64'(result_valid), 64'd0);
    check("async reset result", result, 64'd0);
    check("async reset rd_e", 64'(rd_e), 64'd0);
    start = 1'b0;
    @(negedge clock); #2 reset = 1'b0;
    do_op(3'd0, 64'd2, 64'd2, 5'd15, 64'd4, 65, "MUL 2x2 after reset");

    // Randomized ops against the model
    for (int t = 0; t < 30; t++) begin
      o   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case (sel)
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        2: b = 64'd0;
        3: begin a = MIN_NEG; b = ALL1; end
        4: begin a = -64'($urandom_range(1, 1000)); b = 64'($urandom_range(1, 50)); end
        default: ;
      endcase
      sp = is_special(o, a, b);
      if ($urandom_range(0, 4) == 0) begin
        flush_op(o, a, b, 5'($urandom), sp ? $urandom_range(0, 1) : $urandom_range(0, 65));
      end else begin
        do_op(o, a, b, 5'($urandom), ref_result(o, a, b), sp ? 1 : 65, "random");
      end
    end
    go_idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_controller.md
# execute_muldiv_controller

Iterative 64-bit multiply/divide sequencer that sits beside the ALU in the execute stage of the RV64 pipeline. It accepts one M-extension operation from the execute stage and runs a shift-add multiply or a restoring divide, one bit per cycle. While it runs, it holds the pipeline with a stall signal. It returns the result together with the destination register tag for writeback. It also handles the RISC-V divide-by-zero and signed-overflow special cases in a single cycle.

## Interface
- XLEN, 64, operand/result width; iteration count equals XLEN.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  execute stage presents a valid M-op this cycle.
- flush  in  1  kill the in-flight op (branch/jump redirect).
- op  in  3  operation select:
  - 000 MUL: low XLEN bits.
  - 001 MULHU: high XLEN bits, unsigned.
  - 010 DIVU.
  - 011 REMU.
  - 100 DIV: signed.
  - 101 REM: signed.
  - 11x: reserved, treated as MUL.
- operand_a  in  XLEN  rs1 value (dividend / multiplicand).
- operand_b  in  XLEN  rs2 value (divisor / multiplier).
- destination_register_d  in  5  rd of the op.
- stall  out  1  freeze IF/ID/EX registers.
- busy  out  1  high in BUSY or DONE.
- result_valid  out  1  result present this cycle.
- result  out  XLEN  operation result.
- destination_register_e  out  5  captured rd.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start && !flush captures op, operands and rd.
  - Special case, go directly to DONE:
    - divide with operand_b==0: quotient = all ones; remainder = operand_a.
    - DIV/REM with operand_a==0x8000_0000_0000_0000 and operand_b==all ones: quotient = operand_a; remainder = 0.
  - Otherwise go to BUSY with iteration counter = 0.
- BUSY: one iteration per cycle, 64 iterations.
  - Multiply: 128-bit product register. If the multiplier LSB is set, add the multiplicand to the upper half, then shift right 1. The carry from the add is kept in bit 127 before the shift.
  - Divide: restoring division on magnitudes. Shift the remainder:quotient pair left 1. If remainder ≥ divisor, subtract and set the quotient LSB.
  - Signed ops: magnitudes are taken at capture. Quotient is negated if operand signs differ. Remainder takes the dividend's sign.
  - Counter reaching 63 → DONE on the next edge.
- DONE: result_valid=1 for exactly one cycle, then → IDLE. result and destination_register_e hold their values until the next capture.
- flush:
  - In BUSY or DONE: → IDLE on the next edge.
  - In DONE, flush also gates result_valid combinationally (result_valid = DONE && !flush).
  - In IDLE, flush suppresses start.
- start is ignored in BUSY and DONE. The stalled pipeline keeps start high; this must not cause a re-capture.
- Reset mid-op: state → IDLE immediately. The in-flight op is discarded and no result_valid is produced.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - stall 0, busy 0, result_valid 0.
  - result 0, destination_register_e 0.
  - all internal datapath registers 0.
- stall = (IDLE && start && !flush) || BUSY. This is combinational so the start cycle itself is held. stall is 0 in DONE, so the pipeline advances in the same cycle the result is consumed.
- Normal op: start in cycle 0 (stall=1), BUSY cycles 1–64 (stall=1), DONE cycle 65 (result_valid=1, stall=0). Latency is 65 cycles from start to result_valid.
- Special case: start in cycle 0, DONE in cycle 1. Latency is 1 cycle.
- Back-to-back: a new start can be accepted in the cycle after DONE, i.e. the first IDLE cycle.
- All arithmetic is performed modulo 2^XLEN except the 128-bit product and the internal remainder:quotient register.

## Test plan
- MUL 3 × 4: result_valid in cycle 65 with result=0xC. stall is high in cycles 0–64 and low in cycle 65. destination_register_e equals the captured rd.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → result=0x1. DIVU 100/7 → 14. REMU 100/7 → 2. Each takes 65 cycles.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD (−3). REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF (−1).
- DIVU 5/0 → all ones in cycle 1. REMU 5/0 → 5 in cycle 1. DIV 0x8000…0 / −1 → 0x8000…0 in cycle 1, and REM for the same operands → 0. stall is never high after cycle 0 in any of these.
- flush asserted in cycle 20 of a DIVU with start held high: IDLE on the next cycle, no result_valid, stall low. A new MUL 6 × 7 started afterwards returns 42.
- reset asserted asynchronously mid-BUSY: stall, busy, result_valid and result are all 0 immediately. After deassertion, a MUL 2 × 2 returns 4 with 65-cycle latency.
